// File: rtl/ifu_pkg.sv
// Shared CPU constants for the instruction fetch unit.
package ifu_pkg;

  localparam int CPU_ADDR_WIDTH  = 32;
  localparam int CPU_INSTR_WIDTH = 32;

  localparam logic [CPU_INSTR_WIDTH-1:0] CPU_NOP = '0;

  function automatic logic addr_misaligned(
    input logic [1:0] lsb
  );
    return |lsb;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction bus between the fetch unit (master) and memory (slave).
interface ifu_if;
  import ifu_pkg::*;

  logic [CPU_ADDR_WIDTH-1:0]  o_IAddr;
  logic                       o_IRdC;
  logic [CPU_INSTR_WIDTH-1:0] i_IData;
  logic                       i_IRdy;
  logic                       i_IErr;

  modport master (
    output o_IAddr, o_IRdC,
    input  i_IData, i_IRdy, i_IErr
  );

  modport slave (
    input  o_IAddr, o_IRdC,
    output i_IData, i_IRdy, i_IErr
  );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding bus read per fetch command.
// Optional bus-wait timeout is enabled by defining IFU_BUS_TIMEOUT_EN.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [CPU_ADDR_WIDTH-1:0]  i_addr,
  input  logic                       i_rd_cmd,
  output logic [CPU_INSTR_WIDTH-1:0] o_instr_dat,
  output logic                       o_busy,
  output logic                       o_err_align,
  output logic                       o_err_bus,
  ifu_if.master                      bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]                 r_state;
  logic [CPU_ADDR_WIDTH-1:0]  r_iaddr;
  logic                       r_irdc;
  logic [CPU_INSTR_WIDTH-1:0] r_instr;
  logic                       r_err_align;
  logic                       r_err_bus;

  logic w_idle;
  logic w_wait;
  logic w_accept;
  logic w_misal;
  logic w_tmo;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wait   = (r_state == S_WAIT);
  assign w_accept = w_idle & i_rd_cmd;
  assign w_misal  = addr_misaligned(i_addr[1:0]);

`ifdef IFU_BUS_TIMEOUT_EN
  localparam int unsigned CW =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_tmo_cnt;

  assign w_tmo = w_wait & (r_tmo_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (w_wait & ~bus.i_IRdy & ~bus.i_IErr & ~w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_iaddr     <= '0;
      r_irdc      <= 1'b0;
      r_instr     <= CPU_NOP;
      r_err_align <= 1'b0;
      r_err_bus   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_rd_cmd && w_misal) begin
            r_err_align <= 1'b1;
            r_err_bus   <= 1'b0;
            r_instr     <= CPU_NOP;
          end else if (i_rd_cmd) begin
            r_state     <= S_WAIT;
            r_iaddr     <= i_addr;
            r_irdc      <= 1'b1;
            r_err_align <= 1'b0;
            r_err_bus   <= 1'b0;
          end
        end
        S_WAIT: begin
          // Error (or timeout) takes priority over a same-cycle ready.
          if (bus.i_IErr || w_tmo) begin
            r_state   <= S_IDLE;
            r_irdc    <= 1'b0;
            r_err_bus <= 1'b1;
            r_instr   <= CPU_NOP;
          end else if (bus.i_IRdy) begin
            r_state <= S_IDLE;
            r_irdc  <= 1'b0;
            r_instr <= bus.i_IData;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = w_wait | i_rd_cmd;
  assign o_instr_dat = r_instr;
  assign o_err_align = r_err_align;
  assign o_err_bus   = r_err_bus;
  assign bus.o_IAddr = r_iaddr;
  assign bus.o_IRdC  = r_irdc;

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and nrst as elsewhere in the CPU.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, meaning the bus-wait limit in clk cycles, used only when IFU_BUS_TIMEOUT_EN is defined.
REQ-003 clk  input  1  core clock, all state on rising edge.
REQ-004 nrst  input  1  asynchronous active-low reset.
REQ-005 i_addr  input  CPU_ADDR_WIDTH  fetch address, sampled when i_rd_cmd=1.
REQ-006 i_rd_cmd  input  1  single-cycle read command from the fetch stage.
REQ-007 o_instr_dat  output  CPU_INSTR_WIDTH  registered instruction word of the last completed fetch.
REQ-008 o_busy  output  1  fetch in progress; the fetch stage stalls on it.
REQ-009 o_err_align  output  1  last command had a misaligned address.
REQ-010 o_err_bus  output  1  last command ended in a bus error or timeout.
REQ-011 o_IAddr  output  CPU_ADDR_WIDTH  bus read address.
REQ-012 o_IRdC  output  1  bus read request, held until the request terminates.
REQ-013 i_IData  input  CPU_INSTR_WIDTH  bus read data, valid with i_IRdy.
REQ-014 i_IRdy  input  1  bus read completes this cycle.
REQ-015 i_IErr  input  1  bus read fails this cycle.

Function
REQ-016 The FSM SHALL have two states: IDLE and WAIT.
REQ-017 o_busy SHALL be combinational: (state==WAIT) OR i_rd_cmd. A stall is therefore visible in the same cycle as the command.
REQ-018 IDLE, i_rd_cmd=1, i_addr[1:0]!=0 -> next cycle: o_err_align=1, o_err_bus=0, o_instr_dat=0 (NOP). The FSM stays in IDLE and issues no bus request.
REQ-019 IDLE, i_rd_cmd=1, aligned i_addr -> next cycle: state=WAIT, o_IAddr=i_addr, o_IRdC=1, both error flags cleared.
REQ-020 WAIT, i_IRdy=1 -> next cycle: o_instr_dat=i_IData, o_IRdC=0, state=IDLE, o_busy=0. Minimum latency from command to data is 2 cycles.
REQ-021 WAIT, i_IErr=1 -> next cycle: o_err_bus=1, o_instr_dat=0, o_IRdC=0, state=IDLE. If i_IErr and i_IRdy are both 1 in the same cycle, the error wins.
REQ-022 o_IAddr SHALL stay stable for the whole time o_IRdC=1.
REQ-023 i_rd_cmd while in WAIT SHALL be ignored, with no queueing.
REQ-024 o_instr_dat and both error flags SHALL hold their values until the next accepted i_rd_cmd.
REQ-025 i_IRdy and i_IErr SHALL be ignored while in IDLE.

Reset
REQ-026 When nrst=0, the block SHALL force: state=IDLE, o_IRdC=0, o_IAddr=0, o_instr_dat=0, both error flags=0, timeout counter=0.
REQ-027 A reset during WAIT SHALL abandon the bus request immediately, asynchronously.
REQ-028 A response arriving after reset is released SHALL be ignored, per REQ-025.

Configuration
REQ-029 The macro IFU_BUS_TIMEOUT_EN SHALL control the bus-wait timeout.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without i_IRdy or i_IErr. When it reaches TIMEOUT_CYCLES, the next cycle behaves as REQ-021 (o_err_bus=1, state=IDLE, o_IRdC=0).
- Undefined: no counter exists, and WAIT lasts indefinitely.

Structure
REQ-030 CPU_ADDR_WIDTH, CPU_INSTR_WIDTH and the NOP constant SHALL come from the shared CPU headers.
REQ-031 The FSM state encodings SHALL be local constants.
REQ-032 The design SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Aligned fetch: rd_cmd with addr=0x100, i_IRdy on the 3rd WAIT cycle with i_IData=0x2402000A. Expect o_busy=1 from the cmd cycle onward, o_IAddr=0x100, then o_instr_dat=0x2402000A and o_busy=0.
- Misaligned fetch: rd_cmd with addr=0x102. Expect o_err_align=1, o_instr_dat=0, o_IRdC never asserted.
- Bus error: i_IErr=1 in WAIT, including a case with i_IRdy=1 in the same cycle. Expect o_err_bus=1, o_instr_dat=0; the next aligned fetch clears the flag.
- Timeout (macro defined, TIMEOUT_CYCLES=4): no response. Expect o_err_bus=1 and o_IRdC=0 after 5 WAIT cycles. With the macro undefined, o_busy stays high for 1000 cycles.
- Reset mid-WAIT: expect o_IRdC=0 and o_busy=0 immediately. A late i_IRdy with 0xDEADBEEF leaves o_instr_dat=0.
- Back-to-back fetches 0x0, 0x4, 0x8 with zero bus wait: expect three data words, each 2 cycles apart, and no command lost.
